// File: rtl/ps2_kbd_pkg.sv
// Shared constants, FSM states and key-location payload for the PS/2 to
// ZX Spectrum matrix converter.
package ps2_kbd_pkg;

    localparam int unsigned ROW_W  = 5;
    localparam int unsigned N_ROWS = 8;
    localparam int unsigned N_KEYS = ROW_W * N_ROWS;
    localparam int unsigned N_COMP = 5;

    localparam logic [7:0] C_E0 = 8'hE0;
    localparam logic [7:0] C_F0 = 8'hF0;
    localparam logic [7:0] C_E1 = 8'hE1;
    localparam logic [7:0] C_AA = 8'hAA;
    localparam logic [7:0] C_FA = 8'hFA;
    localparam logic [7:0] C_EE = 8'hEE;
    localparam logic [7:0] C_FE = 8'hFE;
    localparam logic [7:0] C_00 = 8'h00;
    localparam logic [7:0] C_FF = 8'hFF;

    localparam logic [2:0] COMP_BS    = 3'd0;
    localparam logic [2:0] COMP_UP    = 3'd1;
    localparam logic [2:0] COMP_DOWN  = 3'd2;
    localparam logic [2:0] COMP_LEFT  = 3'd3;
    localparam logic [2:0] COMP_RIGHT = 3'd4;

    localparam logic [5:0] IDX_CS = 6'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    typedef struct packed {
        logic       hit;
        logic       is_comp;
        logic [5:0] idx;
    } key_loc_t;

    // Matrix index of the digit a compound key pairs with Caps Shift.
    function automatic logic [5:0] comp_digit(input logic [2:0] c);
        case (c)
            COMP_BS:    return 6'd20;
            COMP_UP:    return 6'd23;
            COMP_DOWN:  return 6'd24;
            COMP_LEFT:  return 6'd19;
            COMP_RIGHT: return 6'd22;
            default:    return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational Set-2 scancode to matrix-location lookup, shared by the
// make and break paths.
module ps2_keymap
    import ps2_kbd_pkg::*;
(
    input  logic       i_ext,
    input  logic [7:0] i_code,
    output key_loc_t   o_loc_c
);

    function automatic key_loc_t k(input logic [5:0] idx);
        return '{hit: 1'b1, is_comp: 1'b0, idx: idx};
    endfunction

    function automatic key_loc_t kc(input logic [2:0] c);
        return '{hit: 1'b1, is_comp: 1'b1, idx: 6'(c)};
    endfunction

    always_comb begin
        o_loc_c = '0;
        if (!i_ext) begin
            case (i_code)
                8'h12: o_loc_c = k(6'd0);
                8'h1A: o_loc_c = k(6'd1);
                8'h22: o_loc_c = k(6'd2);
                8'h21: o_loc_c = k(6'd3);
                8'h2A: o_loc_c = k(6'd4);
                8'h1C: o_loc_c = k(6'd5);
                8'h1B: o_loc_c = k(6'd6);
                8'h23: o_loc_c = k(6'd7);
                8'h2B: o_loc_c = k(6'd8);
                8'h34: o_loc_c = k(6'd9);
                8'h15: o_loc_c = k(6'd10);
                8'h1D: o_loc_c = k(6'd11);
                8'h24: o_loc_c = k(6'd12);
                8'h2D: o_loc_c = k(6'd13);
                8'h2C: o_loc_c = k(6'd14);
                8'h16: o_loc_c = k(6'd15);
                8'h1E: o_loc_c = k(6'd16);
                8'h26: o_loc_c = k(6'd17);
                8'h25: o_loc_c = k(6'd18);
                8'h2E: o_loc_c = k(6'd19);
                8'h45: o_loc_c = k(6'd20);
                8'h46: o_loc_c = k(6'd21);
                8'h3E: o_loc_c = k(6'd22);
                8'h3D: o_loc_c = k(6'd23);
                8'h36: o_loc_c = k(6'd24);
                8'h4D: o_loc_c = k(6'd25);
                8'h44: o_loc_c = k(6'd26);
                8'h43: o_loc_c = k(6'd27);
                8'h3C: o_loc_c = k(6'd28);
                8'h35: o_loc_c = k(6'd29);
                8'h5A: o_loc_c = k(6'd30);
                8'h4B: o_loc_c = k(6'd31);
                8'h42: o_loc_c = k(6'd32);
                8'h3B: o_loc_c = k(6'd33);
                8'h33: o_loc_c = k(6'd34);
                8'h29: o_loc_c = k(6'd35);
                8'h59: o_loc_c = k(6'd36);
                8'h14: o_loc_c = k(6'd36);
                8'h3A: o_loc_c = k(6'd37);
                8'h31: o_loc_c = k(6'd38);
                8'h32: o_loc_c = k(6'd39);
                8'h66: o_loc_c = kc(COMP_BS);
                default: o_loc_c = '0;
            endcase
        end else begin
            // E0 12 / E0 59 are fake shifts and deliberately absent here
            case (i_code)
                8'h75: o_loc_c = kc(COMP_UP);
                8'h72: o_loc_c = kc(COMP_DOWN);
                8'h6B: o_loc_c = kc(COMP_LEFT);
                8'h74: o_loc_c = kc(COMP_RIGHT);
                8'h5A: o_loc_c = k(6'd30);
                8'h14: o_loc_c = k(6'd36);
                default: o_loc_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_matrix_ctrl.sv
// PS/2 Set-2 byte stream to 8x5 ZX Spectrum key matrix, with prefix
// tracking, prefix timeout, Pause swallowing and compound-key synthesis.
module ps2_matrix_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 200000,
    parameter int unsigned E1_SKIP        = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_strobe,
    input  logic [7:0] scan_data,
    output logic [4:0] row_0,
    output logic [4:0] row_1,
    output logic [4:0] row_2,
    output logic [4:0] row_3,
    output logic [4:0] row_4,
    output logic [4:0] row_5,
    output logic [4:0] row_6,
    output logic [4:0] row_7,
    output logic       any_key,
    output logic       overrun
);

    localparam int unsigned TO_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam int unsigned SK_W = (E1_SKIP < 1) ? 1 : $clog2(E1_SKIP + 1);

    state_t              r_state, w_state_nxt;
    logic [TO_W-1:0]     r_to_cnt, w_to_nxt;
    logic [SK_W-1:0]     r_skip, w_skip_nxt;
    logic [N_KEYS-1:0]   r_phys, w_phys_nxt;
    logic [N_COMP-1:0]   r_comp, w_comp_nxt;
    logic [N_KEYS-1:0]   r_rows_n;
    logic                r_any;
    logic                r_ovr;
    logic                w_ovr_nxt;
    logic                w_apply;
    logic                w_make;
    logic                w_ext;
    key_loc_t            w_loc;
    logic [N_KEYS-1:0]   w_pressed;

    assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

    ps2_keymap u_keymap (
        .i_ext   (w_ext),
        .i_code  (scan_data),
        .o_loc_c (w_loc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_to_cnt <= '0;
            r_skip   <= '0;
            r_phys   <= '0;
            r_comp   <= '0;
            r_rows_n <= '1;
            r_any    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_nxt;
            r_skip   <= w_skip_nxt;
            r_phys   <= w_phys_nxt;
            r_comp   <= w_comp_nxt;
            r_rows_n <= ~w_pressed;
            r_any    <= |w_pressed;
            r_ovr    <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to_cnt;
        w_skip_nxt  = r_skip;
        w_phys_nxt  = r_phys;
        w_comp_nxt  = r_comp;
        w_ovr_nxt   = 1'b0;
        w_apply     = 1'b0;
        w_make      = 1'b0;

        if (scan_strobe) begin
            w_to_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    if (scan_data == C_E0) begin
                        w_state_nxt = ST_EXT;
                    end else if (scan_data == C_F0) begin
                        w_state_nxt = ST_BRK;
                    end else if (scan_data == C_E1) begin
                        w_state_nxt = ST_SKIP;
                        w_skip_nxt  = SK_W'(E1_SKIP);
                    end else if (scan_data == C_00 || scan_data == C_FF) begin
                        w_phys_nxt = '0;
                        w_comp_nxt = '0;
                        w_ovr_nxt  = 1'b1;
                    end else if (scan_data != C_AA && scan_data != C_FA &&
                                 scan_data != C_EE && scan_data != C_FE) begin
                        w_apply = 1'b1;
                        w_make  = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scan_data == C_F0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_apply     = 1'b1;
                        w_make      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_SKIP: begin
                    w_skip_nxt = r_skip - SK_W'(1);
                    if (r_skip <= SK_W'(1)) begin
                        w_skip_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE) begin
            // An abandoned prefix is dropped without touching the matrix
            if (r_to_cnt == TO_W'(PREFIX_TIMEOUT - 1)) begin
                w_state_nxt = ST_IDLE;
                w_to_nxt    = '0;
                w_skip_nxt  = '0;
            end else begin
                w_to_nxt = r_to_cnt + TO_W'(1);
            end
        end

        if (w_apply && w_loc.hit) begin
            if (w_loc.is_comp) begin
                w_comp_nxt[w_loc.idx[2:0]] = w_make;
            end else begin
                w_phys_nxt[w_loc.idx] = w_make;
            end
        end
    end

    // Merge physical keys with Caps Shift + digit for held compound keys
    always_comb begin
        w_pressed = w_phys_nxt;
        for (int unsigned c = 0; c < N_COMP; c++) begin
            if (w_comp_nxt[c]) begin
                w_pressed[comp_digit(3'(c))] = 1'b1;
            end
        end
        if (|w_comp_nxt) begin
            w_pressed[IDX_CS] = 1'b1;
        end
    end

    assign row_0   = r_rows_n[4:0];
    assign row_1   = r_rows_n[9:5];
    assign row_2   = r_rows_n[14:10];
    assign row_3   = r_rows_n[19:15];
    assign row_4   = r_rows_n[24:20];
    assign row_5   = r_rows_n[29:25];
    assign row_6   = r_rows_n[34:30];
    assign row_7   = r_rows_n[39:35];
    assign any_key = r_any;
    assign overrun = r_ovr;

endmodule

// File: tb/tb_ps2_matrix_ctrl.sv
// Randomised and directed bench for ps2_matrix_ctrl against a scancode-level
// model of the keyboard matrix.
module tb_ps2_matrix_ctrl;

    localparam int T    = 50;
    localparam int SKIP = 7;

    localparam int P_NONE = 0, P_EXT = 1, P_BRK = 2, P_EXTBRK = 3, P_SKIP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_strobe;
    logic [7:0] scan_data;
    logic [4:0] row_0, row_1, row_2, row_3, row_4, row_5, row_6, row_7;
    logic       any_key;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    ps2_matrix_ctrl #(.PREFIX_TIMEOUT(T), .E1_SKIP(SKIP)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_strobe (scan_strobe),
        .scan_data   (scan_data),
        .row_0       (row_0),
        .row_1       (row_1),
        .row_2       (row_2),
        .row_3       (row_3),
        .row_4       (row_4),
        .row_5       (row_5),
        .row_6       (row_6),
        .row_7       (row_7),
        .any_key     (any_key),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Normal-map codes per row, listed bit4 down to bit0
    logic [7:0] nmap [8][5] = '{
        '{8'h2A, 8'h21, 8'h22, 8'h1A, 8'h12},
        '{8'h34, 8'h2B, 8'h23, 8'h1B, 8'h1C},
        '{8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15},
        '{8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16},
        '{8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45},
        '{8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D},
        '{8'h33, 8'h3B, 8'h42, 8'h4B, 8'h5A},
        '{8'h32, 8'h31, 8'h3A, 8'h59, 8'h29}
    };
    // Digit each compound key (BS, Up, Down, Left, Right) pairs with CS
    int cdig [5] = '{0, 7, 6, 5, 8};
    logic [7:0] xcodes [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h14, 8'h12, 8'h59};

    bit     m_phys [40];
    bit     m_comp [5];
    int     pend;
    int     skip_left;
    longint cyc;
    longint last_strobe;
    bit     exp_ovr;
    bit     chk_en = 1'b0;

    function automatic int dig_idx(input int d);
        if (d >= 1 && d <= 5) return 14 + d;
        return 20 + ((d == 0) ? 0 : 10 - d);
    endfunction

    function automatic void lookup(input bit ext, input logic [7:0] b, output int pi, output int ci);
        pi = -1;
        ci = -1;
        if (!ext) begin
            for (int r = 0; r < 8; r++)
                for (int j = 0; j < 5; j++)
                    if (nmap[r][j] == b) pi = r * 5 + 4 - j;
            if (b == 8'h14) pi = 36;
            if (b == 8'h66) ci = 0;
        end else begin
            case (b)
                8'h75: ci = 1;
                8'h72: ci = 2;
                8'h6B: ci = 3;
                8'h74: ci = 4;
                8'h5A: pi = 30;
                8'h14: pi = 36;
                default: ;
            endcase
        end
    endfunction

    function automatic void apply(input bit ext, input logic [7:0] b, input bit mk);
        int pi, ci;
        lookup(ext, b, pi, ci);
        if (pi >= 0) m_phys[pi] = mk;
        if (ci >= 0) m_comp[ci] = mk;
    endfunction

    function automatic void clear_keys();
        for (int i = 0; i < 40; i++) m_phys[i] = 1'b0;
        for (int c = 0; c < 5; c++) m_comp[c] = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (pend != P_NONE && (cyc - last_strobe) > T) pend = P_NONE;
        last_strobe = cyc;
        case (pend)
            P_NONE: begin
                if (b == 8'hE0) pend = P_EXT;
                else if (b == 8'hF0) pend = P_BRK;
                else if (b == 8'hE1) begin pend = P_SKIP; skip_left = SKIP; end
                else if (b == 8'h00 || b == 8'hFF) begin clear_keys(); exp_ovr = 1'b1; end
                else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) ;
                else apply(1'b0, b, 1'b1);
            end
            P_EXT: begin
                if (b == 8'hF0) pend = P_EXTBRK;
                else begin apply(1'b1, b, 1'b1); pend = P_NONE; end
            end
            P_BRK:    begin apply(1'b0, b, 1'b0); pend = P_NONE; end
            P_EXTBRK: begin apply(1'b1, b, 1'b0); pend = P_NONE; end
            default: begin
                skip_left--;
                if (skip_left <= 0) pend = P_NONE;
            end
        endcase
    endfunction

    function automatic logic [39:0] exp_pressed();
        logic [39:0] p;
        bit anyc;
        anyc = 1'b0;
        for (int i = 0; i < 40; i++) p[i] = m_phys[i];
        for (int c = 0; c < 5; c++)
            if (m_comp[c]) begin
                anyc = 1'b1;
                p[dig_idx(cdig[c])] = 1'b1;
            end
        if (anyc) p[0] = 1'b1;
        return p;
    endfunction

    // Model advances on the same edge the DUT registers
    always @(posedge clk) begin
        cyc++;
        exp_ovr = 1'b0;
        if (reset) begin
            clear_keys();
            pend        = P_NONE;
            skip_left   = 0;
            last_strobe = cyc;
            chk_en      = 1'b1;
        end else if (scan_strobe) begin
            model_byte(scan_data);
        end
    end

    logic [39:0] exp_rows, dut_rows;
    bit          exp_any;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_rows = ~exp_pressed();
            exp_any  = |exp_pressed();
            dut_rows = {row_7, row_6, row_5, row_4, row_3, row_2, row_1, row_0};
            total += 3;
            if (dut_rows !== exp_rows) begin
                bad++;
                $display("FAIL rows @%0t: got %h want %h", $time, dut_rows, exp_rows);
            end
            if (any_key !== exp_any) begin
                bad++;
                $display("FAIL any_key @%0t: got %b want %b", $time, any_key, exp_any);
            end
            if (overrun !== exp_ovr) begin
                bad++;
                $display("FAIL overrun @%0t: got %b want %b", $time, overrun, exp_ovr);
            end
        end
    end

    task automatic lit(input string nm, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        scan_strobe = 1'b1;
        scan_data   = b;
        @(posedge clk); #1;
        scan_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse(input bit with_strobe, input logic [7:0] b);
        @(posedge clk); #1;
        reset       = 1'b1;
        scan_strobe = with_strobe;
        scan_data   = b;
        @(posedge clk); #1;
        reset       = 1'b0;
        scan_strobe = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 99);
        if (r < 40) return nmap[$urandom_range(0, 7)][$urandom_range(0, 4)];
        if (r < 44) return 8'h66;
        if (r < 54) return xcodes[$urandom_range(0, 7)];
        if (r < 66) return 8'hF0;
        if (r < 75) return 8'hE0;
        if (r < 78) return 8'hE1;
        if (r < 83) begin
            case ($urandom_range(0, 3))
                0: return 8'hAA;
                1: return 8'hFA;
                2: return 8'hEE;
                default: return 8'hFE;
            endcase
        end
        if (r < 85) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        reset       = 1'b1;
        scan_strobe = 1'b0;
        scan_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        lit("reset_row3", row_3, 5'b11111);
        lit("reset_any", {4'b0, any_key}, 5'b0);

        send(8'h1C);
        lit("a_make_row1", row_1, 5'b11110);
        lit("a_make_any", {4'b0, any_key}, 5'b1);
        send(8'hF0); send(8'h1C);
        lit("a_break_row1", row_1, 5'b11111);
        lit("a_break_any", {4'b0, any_key}, 5'b0);

        send(8'hE0); send(8'h75);
        lit("up_row0", row_0, 5'b11110);
        lit("up_row4", row_4, 5'b10111);
        send(8'hE0); send(8'hF0); send(8'h75);
        lit("up_rel_row0", row_0, 5'b11111);
        lit("up_rel_row4", row_4, 5'b11111);

        send(8'h12); send(8'h66);
        lit("bs_row0", row_0, 5'b11110);
        lit("bs_row4", row_4, 5'b11110);
        send(8'hF0); send(8'h66);
        lit("bs_rel_row4", row_4, 5'b11111);
        lit("bs_rel_row0_held", row_0, 5'b11110);
        send(8'hF0); send(8'h12);
        lit("shift_rel_row0", row_0, 5'b11111);

        send(8'hE0); idle(T + 10); send(8'h1C);
        lit("e0_timeout_row1", row_1, 5'b11110);
        send(8'hF0); idle(T + 10); send(8'h1C);
        lit("f0_timeout_row1", row_1, 5'b11110);
        send(8'hF0); send(8'h1C);

        // Next byte exactly PREFIX_TIMEOUT cycles after E0 still counts
        send(8'hE0); idle(T - 2); send(8'h75);
        lit("edge_valid_row4", row_4, 5'b10111);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); idle(T - 1); send(8'h75);
        lit("edge_expired_row4", row_4, 5'b11111);
        lit("edge_expired_row0", row_0, 5'b11111);

        send(8'hE1);
        send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
        send(8'h14); send(8'hF0); send(8'h77);
        lit("pause_row7", row_7, 5'b11111);
        lit("pause_any", {4'b0, any_key}, 5'b0);
        send(8'h29);
        lit("space_row7", row_7, 5'b11110);
        send(8'hAA); send(8'hFA);
        lit("status_row7", row_7, 5'b11110);

        send(8'h1C);
        send(8'hFF);
        lit("ovr_pulse", {4'b0, overrun}, 5'b1);
        lit("ovr_row1", row_1, 5'b11111);
        lit("ovr_row7", row_7, 5'b11111);
        idle(1);
        lit("ovr_drop", {4'b0, overrun}, 5'b0);

        send(8'hE0);
        rst_pulse(1'b0, 8'h00);
        send(8'h75);
        lit("rst_e0_row0", row_0, 5'b11111);
        lit("rst_e0_row4", row_4, 5'b11111);
        rst_pulse(1'b1, 8'h1C);
        lit("rst_strobe_row1", row_1, 5'b11111);

        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) rst_pulse(1'($urandom_range(0, 1)), pick());
            else if (r < 5) idle($urandom_range(T - 4, T + 2));
            else begin
                send(pick());
                idle($urandom_range(0, 2));
            end
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
